sa_pe: RTL

Parametrised output-stationary processing element for the systolic array. It is the generalised successor of the fixed 16-bit PE. Each instance multiplies signed operands streaming in from the west (A) and north (B), forwards them east and south one cycle later, and accumulates a dot product over a tile framed by valid/last flags. Finished results are double-buffered and leave the array through a per-column shift-drain chain, so the next tile can accumulate while the previous one drains.

---
 rtl/sa_pkg.sv | 24 ++
 rtl/sa_pe_mac.sv | 55 +++++
 rtl/sa_pe.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared definitions for the systolic-array processing element.
//   DATA_W_DEF / ACC_W_DEF : default operand and accumulator widths
//   drain_state_e          : per-PE drain chain state (D_IDLE, D_SHIFT)
//   ACC_MAX / ACC_MIN      : largest / smallest signed value of an acc_w-bit word
package sa_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 40;
  localparam int MAX_ACC_W  = 128;

  typedef enum logic {
    D_IDLE  = 1'b0,
    D_SHIFT = 1'b1
  } drain_state_e;

  function automatic logic signed [MAX_ACC_W-1:0] ACC_MAX(input int acc_w);
    return (128'sd1 <<< (acc_w - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [MAX_ACC_W-1:0] ACC_MIN(input int acc_w);
    return -(128'sd1 <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/sa_pe_mac.sv
// sa_pe_mac: combinational multiply-accumulate for one PE.
//   a, b  : signed operands (DATA_W)
//   acc   : current accumulator (ACC_W)
//   first : 1 = start a fresh dot product (ignore acc)
//   sum   : next accumulator value (ACC_W)
//   ovf   : the signed add left the ACC_W range
// Optional feature macro: PE_SATURATE_EN (clamp on overflow instead of wrapping).
module sa_pe_mac
  import sa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [ACC_W-1:0]  acc,
  input  logic                     first,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W:0]      prod_x;
  logic signed [ACC_W:0]      addend_x;
  logic signed [ACC_W:0]      sum_x;

`ifdef PE_SATURATE_EN
  localparam logic signed [MAX_ACC_W-1:0] MAX_FULL = ACC_MAX(ACC_W);
  localparam logic signed [MAX_ACC_W-1:0] MIN_FULL = ACC_MIN(ACC_W);
  localparam logic signed [ACC_W-1:0]     SAT_MAX  = MAX_FULL[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0]     SAT_MIN  = MIN_FULL[ACC_W-1:0];

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] wide);
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      return wide[ACC_W] ? SAT_MIN : SAT_MAX;
    end
    return wide[ACC_W-1:0];
  endfunction
`endif

  always_comb begin
    prod     = a * b;
    prod_x   = (ACC_W+1)'(prod);
    addend_x = first ? '0 : (ACC_W+1)'(acc);
    // One guard bit: the two top bits disagree exactly when the result left the ACC_W range.
    sum_x    = addend_x + prod_x;
    ovf      = sum_x[ACC_W] ^ sum_x[ACC_W-1];
`ifdef PE_SATURATE_EN
    sum      = sat_acc(sum_x);
`else
    sum      = sum_x[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/sa_pe.sv
// sa_pe: output-stationary systolic-array processing element.
//   CLK, RST (sync, active-high), EN (0 freezes all state)
//   A_in/B_in/V_in/L_in     : west/north operands, pair valid, last pair of tile
//   A_out/B_out/V_out/L_out : the same, registered, to east/south neighbours
//   DRAIN                   : column-wide drain request
//   C_in/C_in_valid         : drain chain from the PE above
//   C_out/C_out_valid       : drain chain toward the array edge
//   RES_VALID               : result buffer holds an undrained result
//   OVF                     : sticky accumulator overflow
// Optional feature macro: PE_SATURATE_EN (saturating accumulator, in sa_pe_mac).
module sa_pe
  import sa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic signed [DATA_W-1:0] A_in,
  input  logic signed [DATA_W-1:0] B_in,
  input  logic                     V_in,
  input  logic                     L_in,
  output logic signed [DATA_W-1:0] A_out,
  output logic signed [DATA_W-1:0] B_out,
  output logic                     V_out,
  output logic                     L_out,
  input  logic                     DRAIN,
  input  logic signed [ACC_W-1:0]  C_in,
  input  logic                     C_in_valid,
  output logic signed [ACC_W-1:0]  C_out,
  output logic                     C_out_valid,
  output logic                     RES_VALID,
  output logic                     OVF
);

  if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
    $error("sa_pe: ACC_W must be at least 2*DATA_W");
  end

  logic signed [DATA_W-1:0] a_p1_q, a_p1_d, b_p1_q, b_p1_d;
  logic                     vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
  logic signed [ACC_W-1:0]  acc_p2_q, acc_p2_d, res_q, res_d, c_out_q, c_out_d;
  logic                     first_q, first_d, ovf_q, ovf_d;
  logic                     res_valid_q, res_valid_d, c_out_valid_q, c_out_valid_d;
  drain_state_e             state_q, state_d;
  logic signed [ACC_W-1:0]  mac_sum;
  logic                     mac_ovf;

  sa_pe_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .a     (a_p1_q),
    .b     (b_p1_q),
    .acc   (acc_p2_q),
    .first (first_q),
    .sum   (mac_sum),
    .ovf   (mac_ovf)
  );

  always_comb begin
    a_p1_d        = a_p1_q;
    b_p1_d        = b_p1_q;
    vld_p1_d      = vld_p1_q;
    last_p1_d     = last_p1_q;
    acc_p2_d      = acc_p2_q;
    first_d       = first_q;
    ovf_d         = ovf_q;
    res_d         = res_q;
    res_valid_d   = res_valid_q;
    c_out_d       = c_out_q;
    c_out_valid_d = c_out_valid_q;
    state_d       = state_q;
    if (EN) begin
      // Stage 1: operand capture / forwarding
      a_p1_d    = A_in;
      b_p1_d    = B_in;
      vld_p1_d  = V_in;
      last_p1_d = L_in;
      // Stage 2: accumulate
      if (vld_p1_q) begin
        acc_p2_d = mac_sum;
        first_d  = last_p1_q;
        ovf_d    = ovf_q | mac_ovf;
      end
      // Drain chain
      if (DRAIN) begin
        if (state_q == D_IDLE) begin
          c_out_d       = res_q;
          c_out_valid_d = res_valid_q;
          res_valid_d   = 1'b0;
          state_d       = D_SHIFT;
        end else begin
          c_out_d       = C_in;
          c_out_valid_d = C_in_valid;
        end
      end else begin
        state_d       = D_IDLE;
        c_out_valid_d = 1'b0;
      end
      // Completion is applied after the load so a same-cycle result survives the clear.
      if (vld_p1_q && last_p1_q) begin
        res_d       = mac_sum;
        res_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_p1_q        <= '0;
      b_p1_q        <= '0;
      vld_p1_q      <= 1'b0;
      last_p1_q     <= 1'b0;
      acc_p2_q      <= '0;
      first_q       <= 1'b1;
      ovf_q         <= 1'b0;
      res_q         <= '0;
      res_valid_q   <= 1'b0;
      c_out_q       <= '0;
      c_out_valid_q <= 1'b0;
      state_q       <= D_IDLE;
    end else begin
      a_p1_q        <= a_p1_d;
      b_p1_q        <= b_p1_d;
      vld_p1_q      <= vld_p1_d;
      last_p1_q     <= last_p1_d;
      acc_p2_q      <= acc_p2_d;
      first_q       <= first_d;
      ovf_q         <= ovf_d;
      res_q         <= res_d;
      res_valid_q   <= res_valid_d;
      c_out_q       <= c_out_d;
      c_out_valid_q <= c_out_valid_d;
      state_q       <= state_d;
    end
  end

  assign A_out       = a_p1_q;
  assign B_out       = b_p1_q;
  assign V_out       = vld_p1_q;
  assign L_out       = last_p1_q;
  assign C_out       = c_out_q;
  assign C_out_valid = c_out_valid_q;
  assign RES_VALID   = res_valid_q;
  assign OVF         = ovf_q;

endmodule
